// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Widths here are the defaults; fetch_queue re-derives its entry layout from its own parameters.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int PC_STEP     = 4;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pcplus4;
    } fetch_entry_t;

    // Queue occupancy / credit counters need to hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic                           clear,
    output logic [count_width(DEPTH)-1:0]  count,
    output logic [WIDTH-1:0]               head,
    output logic                           empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only ever read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues credit-limited requests to
// instruction memory, buffers responses and hands them to decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    output logic                          imem_req_o,
    output logic [ADDR_W-1:0]             imem_addr_o,
    input  logic                          imem_ack_i,
    input  logic                          imem_rvalid_i,
    input  logic [INSTR_W-1:0]            imem_rdata_i,
    output logic                          dec_valid_o,
    output logic [INSTR_W-1:0]            dec_instr_o,
    output logic [ADDR_W-1:0]             dec_pcplus4_o,
    input  logic                          dec_ready_i,
    input  logic                          redirect_i,
    input  logic [ADDR_W-1:0]             redirect_pc_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int CNT_W = count_width(DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pcplus4;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] target_pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  inflight_next;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;
    logic              req_fire;
    logic              resp_take;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    entry_t            push_entry;
    entry_t            head_entry;

    assign target_pc   = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign credit_used = {1'b0, count} + {1'b0, inflight};

    // Queued plus outstanding words never exceed DEPTH, so a response always has a slot.
    assign imem_req_o  = !reset_i && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign req_fire    = imem_req_o && imem_ack_i;

    // A response with nothing outstanding is a stray (e.g. from before a reset).
    assign resp_take   = imem_rvalid_i && (inflight != '0);

    assign fifo_push   = resp_take && (discard == '0) && !redirect_i;
    assign fifo_pop    = dec_valid_o && dec_ready_i && !redirect_i;

    assign push_entry.instr   = imem_rdata_i;
    assign push_entry.pcplus4 = resp_pc + ADDR_W'(PC_STEP);

    always_comb begin
        inflight_next = inflight;
        case ({req_fire, resp_take})
            2'b10:   inflight_next = inflight + CNT_W'(1);
            2'b01:   inflight_next = inflight - CNT_W'(1);
            default: inflight_next = inflight;
        endcase
    end

    // A redirect turns every request still outstanding after this cycle into a discard.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_i) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                discard  <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                end
                if (resp_take) begin
                    if (discard != '0) begin
                        discard <= discard - CNT_W'(1);
                    end else begin
                        resp_pc <= resp_pc + ADDR_W'(PC_STEP);
                    end
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .clear     (redirect_i),
        .count     (count),
        .head      (head_entry),
        .empty     (fifo_empty)
    );

    // Decode sees zeros whenever the queue is empty rather than a stale slot.
    assign dec_valid_o   = !fifo_empty;
    assign dec_instr_o   = dec_valid_o ? head_entry.instr : '0;
    assign dec_pcplus4_o = dec_valid_o ? head_entry.pcplus4 : '0;
    assign count_o       = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed cycle-by-cycle vectors for fetch_queue; the bench plays the
// instruction memory by driving ack/rvalid straight from each vector.
module tb_fetch_queue;

    logic        clk_i;
    logic        reset_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pcplus4_o;
    logic        dec_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ack;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        int          exp_count;
    } vec_t;

    vec_t vecs[$];

    fetch_queue #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .dec_valid_o   (dec_valid_o),
        .dec_instr_o   (dec_instr_o),
        .dec_pcplus4_o (dec_pcplus4_o),
        .dec_ready_i   (dec_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .count_o       (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic ack, input logic rvalid, input logic [31:0] rdata,
                                input logic ready, input logic redir, input logic [31:0] rpc,
                                input logic exp_req, input logic [31:0] exp_addr,
                                input logic exp_valid, input logic [31:0] exp_instr,
                                input logic [31:0] exp_pc4, input int exp_count);
        vec_t v;
        v.ack = ack;             v.rvalid = rvalid;       v.rdata = rdata;
        v.ready = ready;         v.redir = redir;         v.rpc = rpc;
        v.exp_req = exp_req;     v.exp_addr = exp_addr;   v.exp_valid = exp_valid;
        v.exp_instr = exp_instr; v.exp_pc4 = exp_pc4;     v.exp_count = exp_count;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, " req"},     32'(imem_req_o),  32'(v.exp_req));
        checkOutput({tag, " addr"},    imem_addr_o,      v.exp_addr);
        checkOutput({tag, " valid"},   32'(dec_valid_o), 32'(v.exp_valid));
        checkOutput({tag, " instr"},   dec_instr_o,      v.exp_instr);
        checkOutput({tag, " pcplus4"}, dec_pcplus4_o,    v.exp_pc4);
        checkOutput({tag, " count"},   32'(count_o),     32'(v.exp_count));
    endtask

    // Called at posedge+1: drive, check pre-edge outputs at negedge, then take the edge.
    task automatic applyStimulus(input string tag, input vec_t v);
        imem_ack_i    = v.ack;
        imem_rvalid_i = v.rvalid;
        imem_rdata_i  = v.rdata;
        dec_ready_i   = v.ready;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        @(negedge clk_i);
        checkAll(tag, v);
        @(posedge clk_i);
        #1;
    endtask

    task automatic clearInputs();
        imem_ack_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        dec_ready_i   = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
    endtask

    initial begin
        vec_t zero_v;
        reset_i = 1'b1;
        clearInputs();
        zero_v = mk(0,0,0, 0,0,0, 0,32'h0, 0,32'h0,32'h0, 0);

        // ack, rvalid, rdata, ready, redir, rpc | req, addr, valid, instr, pcplus4, count
        vecs.push_back(mk(1,0,32'h0,        1,0,32'h0,   1,32'h0,   0,32'h0,        32'h0,   0));
        vecs.push_back(mk(1,1,32'h1000_0000,1,0,32'h0,   1,32'h4,   0,32'h0,        32'h0,   0));
        vecs.push_back(mk(1,1,32'h1000_0001,1,0,32'h0,   1,32'h8,   1,32'h1000_0000,32'h4,   1));
        vecs.push_back(mk(1,1,32'h1000_0002,1,0,32'h0,   1,32'hC,   1,32'h1000_0001,32'h8,   1));
        vecs.push_back(mk(1,1,32'h1000_0003,0,0,32'h0,   1,32'h10,  1,32'h1000_0002,32'hC,   1));
        vecs.push_back(mk(1,1,32'h1000_0004,0,0,32'h0,   1,32'h14,  1,32'h1000_0002,32'hC,   2));
        vecs.push_back(mk(0,1,32'h1000_0005,0,0,32'h0,   0,32'h18,  1,32'h1000_0002,32'hC,   3));
        vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,   0,32'h18,  1,32'h1000_0002,32'hC,   4));
        vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,   0,32'h18,  1,32'h1000_0002,32'hC,   4));
        vecs.push_back(mk(1,0,32'h0,        0,0,32'h0,   1,32'h18,  1,32'h1000_0003,32'h10,  3));
        vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,   0,32'h1C,  1,32'h1000_0003,32'h10,  3));
        vecs.push_back(mk(1,0,32'h0,        1,0,32'h0,   1,32'h1C,  1,32'h1000_0004,32'h14,  2));
        vecs.push_back(mk(1,0,32'h0,        1,0,32'h0,   1,32'h20,  1,32'h1000_0005,32'h18,  1));
        vecs.push_back(mk(0,0,32'h0,        1,1,32'h103, 1,32'h24,  0,32'h0,        32'h0,   0));
        vecs.push_back(mk(1,1,32'hDEAD_0000,1,0,32'h0,   1,32'h100, 0,32'h0,        32'h0,   0));
        vecs.push_back(mk(0,1,32'hDEAD_0001,1,0,32'h0,   1,32'h104, 0,32'h0,        32'h0,   0));
        vecs.push_back(mk(0,1,32'hDEAD_0002,1,0,32'h0,   1,32'h104, 0,32'h0,        32'h0,   0));
        vecs.push_back(mk(1,1,32'h2000_0000,1,0,32'h0,   1,32'h104, 0,32'h0,        32'h0,   0));
        vecs.push_back(mk(1,1,32'hDEAD_0100,1,1,32'h200, 1,32'h108, 1,32'h2000_0000,32'h104, 1));
        vecs.push_back(mk(1,1,32'hDEAD_0101,1,0,32'h0,   1,32'h200, 0,32'h0,        32'h0,   0));
        vecs.push_back(mk(0,1,32'h3000_0000,1,0,32'h0,   1,32'h204, 0,32'h0,        32'h0,   0));
        vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,   1,32'h204, 1,32'h3000_0000,32'h204, 1));
        vecs.push_back(mk(0,1,32'hBAD0_BAD0,1,0,32'h0,   1,32'h204, 0,32'h0,        32'h0,   0));
        vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,   1,32'h204, 0,32'h0,        32'h0,   0));

        repeat (3) @(posedge clk_i);
        #1;
        checkAll("reset", zero_v);
        reset_i = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // PC wrap from the last word back to zero.
        applyStimulus("wrap0", mk(0,0,32'h0,        0,1,32'hFFFF_FFFC, 1,32'h204,       0,32'h0,        32'h0, 0));
        applyStimulus("wrap1", mk(1,0,32'h0,        0,0,32'h0,         1,32'hFFFF_FFFC, 0,32'h0,        32'h0, 0));
        applyStimulus("wrap2", mk(0,1,32'h4000_0000,0,0,32'h0,         1,32'h0,         0,32'h0,        32'h0, 0));
        applyStimulus("wrap3", mk(0,0,32'h0,        0,0,32'h0,         1,32'h0,         1,32'h4000_0000,32'h0, 1));

        // Reset with two requests outstanding; their late responses must be ignored.
        applyStimulus("rst0",  mk(1,0,32'h0,        0,0,32'h0,         1,32'h0,         1,32'h4000_0000,32'h0, 1));
        applyStimulus("rst1",  mk(1,0,32'h0,        0,0,32'h0,         1,32'h4,         1,32'h4000_0000,32'h0, 1));
        clearInputs();
        reset_i = 1'b1;
        #1;
        checkAll("midreset", zero_v);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        applyStimulus("late0", mk(0,1,32'hBAD0_0001,0,0,32'h0, 1,32'h0, 0,32'h0,        32'h0, 0));
        applyStimulus("late1", mk(0,1,32'hBAD0_0002,0,0,32'h0, 1,32'h0, 0,32'h0,        32'h0, 0));
        applyStimulus("late2", mk(1,0,32'h0,        0,0,32'h0, 1,32'h0, 0,32'h0,        32'h0, 0));
        applyStimulus("late3", mk(0,1,32'h5000_0000,0,0,32'h0, 1,32'h4, 0,32'h0,        32'h0, 0));
        applyStimulus("late4", mk(0,0,32'h0,        1,0,32'h0, 1,32'h4, 1,32'h5000_0000,32'h4, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
